// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Contents:
//   ST_*            FSM state encoding (IDLE=0, COLLECT=1, WRITE=2, DONE=3)
//   BYTES_PER_WORD  stream bytes packed into one instruction word
//   ADDR_STEP       byte distance between consecutive words; the PC adder uses the same step
//   COUNT_W         width of the requested word count
//   clamp_count()   limits a requested word count to the memory depth
package imem_loader_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;
  localparam int COUNT_W        = 7;

  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] requested,
                                                     input logic [COUNT_W-1:0] limit);
    return (requested > limit) ? limit : requested;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: collects the first three bytes of a word in a
// lane register and merges the fourth byte on the fly, so the full word is
// available in the same cycle that its last byte is accepted.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; empties the packer
//   clear      restarts at lane 0 (new session)
//   load       a stream byte is accepted this cycle
//   byte_in    the stream byte
//   word       packed word {byte_in, lane2, lane1, lane0}; valid when word_full
//   word_full  the byte being loaded completes a word
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0]                 lane;
  logic [8*(BYTES_PER_WORD-1)-1:0]   low_lanes;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane      <= '0;
      low_lanes <= '0;
    end else if (load) begin
      lane <= lane + 1'b1;  // wraps back to lane 0 after the last byte
      for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
        if (lane == LANE_W'(k)) low_lanes[8*k +: 8] <= byte_in;
      end
    end
  end

  assign word      = {byte_in, low_lanes};
  assign word_full = load && (lane == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Write side of the instruction memory. Packs a valid/ready byte stream
// little-endian into 32-bit words and writes them to consecutive word-aligned
// addresses, holding the CPU in reset for the whole session.
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   start        1-cycle session request, honoured in IDLE only
//   word_count   words to load, latched on an accepted start
//   rx_data      stream byte; rx_valid/rx_ready handshake
//   wr_en        1-cycle write strobe with wr_addr (byte address) and wr_data
//   cpu_hold     keeps the PC in reset while high (same as busy)
//   busy         session in progress
//   done         1-cycle pulse at session end
//   err          sticky: requested word_count exceeded DEPTH
// All outputs are registered; each is loaded from the next-state decode.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] word_count,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [31:0]        wr_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  STEP_C  = ADDR_W'(ADDR_STEP);

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [COUNT_W-1:0] words_left;
  logic [COUNT_W-1:0] request;
  logic               start_ok;
  logic               accept;
  logic               word_full;
  logic [31:0]        packed_word;

  assign start_ok = (state == ST_IDLE) && start;
  assign accept   = rx_valid && rx_ready;  // rx_ready is only high in COLLECT
  assign request  = clamp_count(word_count, DEPTH_C);

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .load      (accept),
    .byte_in   (rx_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = (request == '0) ? ST_DONE : ST_COLLECT;
      ST_COLLECT: if (word_full) next_state = ST_WRITE;
      ST_WRITE:   next_state = (words_left == COUNT_W'(1)) ? ST_DONE : ST_COLLECT;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rx_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_left <= '0;
    end else begin
      state    <= next_state;
      rx_ready <= (next_state == ST_COLLECT);
      wr_en    <= (next_state == ST_WRITE);
      busy     <= (next_state != ST_IDLE);
      cpu_hold <= (next_state != ST_IDLE);
      done     <= (next_state == ST_DONE);

      if (start_ok) begin
        words_left <= request;
        err        <= (word_count > DEPTH_C);
        wr_addr    <= BASE_ADDR;
      end

      // wr_data only changes when a word completes, so it holds between writes.
      if (word_full) wr_data <= packed_word;

      // Advance after the write cycle; the address wraps modulo 2^ADDR_W.
      if (state == ST_WRITE) begin
        wr_addr    <= wr_addr + STEP_C;
        words_left <= words_left - COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A session-level model (byte list,
// word index, expected-write queue with due cycles) predicts every output on
// every cycle; directed tests add literal expectations on top.
module tb_imem_loader;

  localparam int          DEPTH = 64;
  localparam logic [7:0]  BASE  = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.ADDR_W(8), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- model state ----------------
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t         exp_q[$];
  int          cyc         = 0;
  bit          m_busy      = 0;
  bit          m_err       = 0;
  bit          m_rst_check = 0;
  int          m_n         = 0;
  int          m_bytes     = 0;
  int          m_words     = 0;
  int          m_end       = -1;
  logic [31:0] m_word      = '0;
  logic [31:0] m_last_data = '0;

  // observation statistics for directed checks
  int          wr_count   = 0;
  int          done_count = 0;
  int          rdy_count  = 0;
  logic [7:0]  obs_addr[$];
  logic [31:0] obs_data[$];

  // Compare then advance the model, once per cycle on the falling edge.
  initial begin
    bit exp_wr, exp_done, exp_ready;
    wr_t w;
    forever begin
      @(negedge clk);
      cyc++;
      exp_wr    = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      exp_done  = m_busy && (cyc == m_end);
      exp_ready = m_busy && (m_bytes < 4 * m_n) && !exp_wr;

      if (m_rst_check) begin
        check("rst_wr_addr", 32'(wr_addr), 32'(BASE));
        check("rst_wr_data", wr_data, 32'h0);
      end
      check("wr_en", 32'(wr_en), 32'(exp_wr));
      if (exp_wr) begin
        w = exp_q.pop_front();
        if (wr_en) begin
          check("wr_addr", 32'(wr_addr), 32'(w.addr));
          check("wr_data", wr_data, w.data);
        end
        m_last_data = w.data;
      end else begin
        check("wr_data_hold", wr_data, m_last_data);
      end
      if (wr_en) begin
        wr_count++;
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
      end
      check("rx_ready", 32'(rx_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_busy));
      check("cpu_hold", 32'(cpu_hold), 32'(m_busy));
      check("done", 32'(done), 32'(exp_done));
      check("err", 32'(err), 32'(m_err));
      if (rx_ready) rdy_count++;
      if (done) done_count++;

      // inputs seen now take effect at the next rising edge
      m_rst_check = reset;
      if (reset) begin
        m_busy = 0; m_err = 0; m_n = 0; m_bytes = 0; m_words = 0;
        m_end = -1; m_last_data = '0;
        exp_q.delete();
      end else begin
        if (start && !m_busy) begin
          m_n     = (word_count > DEPTH) ? DEPTH : int'(word_count);
          m_err   = (word_count > DEPTH);
          m_bytes = 0;
          m_words = 0;
          m_busy  = 1;
          m_end   = (m_n == 0) ? cyc + 1 : -1;
        end else if (m_busy && cyc == m_end) begin
          m_busy = 0;
        end
        if (rx_valid && exp_ready) begin
          m_word[8*(m_bytes % 4) +: 8] = rx_data;
          m_bytes++;
          if (m_bytes % 4 == 0) begin
            exp_q.push_back('{addr: 8'(int'(BASE) + 4 * m_words), data: m_word, due: cyc + 1});
            m_words++;
            if (m_bytes == 4 * m_n) m_end = cyc + 2;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic clear_stats();
    wr_count = 0; done_count = 0; rdy_count = 0;
    obs_addr.delete(); obs_data.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [6:0] wc);
    start = 1'b1; word_count = wc;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd, output int waited);
    bit took;
    took = 0; waited = 0;
    rx_data = b;
    while (!took && waited < 64) begin
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      took = rx_valid && rx_ready;
      waited++;
      step();
    end
    rx_valid = 1'b0;
    if (!took) check("byte_timeout", 32'(took), 32'h1);
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input bit rnd);
    int w;
    foreach (bytes[i]) send_byte(bytes[i], rnd, w);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int         w;
    reset = 1'b1; start = 1'b0; word_count = '0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rx_ready", 32'(rx_ready), 32'h0);
    check("reset_wr_addr", 32'(wr_addr), 32'h0);

    // 1: two words, plain stream
    clear_stats();
    do_start(7'd2);
    q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_bytes(q, 0);
    wait_idle();
    check("t1_count", 32'(wr_count), 32'd2);
    check("t1_addr0", 32'(obs_addr[0]), 32'h00);
    check("t1_data0", obs_data[0], 32'h00000013);
    check("t1_addr1", 32'(obs_addr[1]), 32'h04);
    check("t1_data1", obs_data[1], 32'h00100093);
    check("t1_done", 32'(done_count), 32'd1);

    // 2: random rx_valid and a byte offered during the WRITE bubble
    clear_stats();
    do_start(7'd2);
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(q, 1);
    rx_data = 8'h55; rx_valid = 1'b1;
    @(negedge clk);
    check("t2_bubble_wr_en", 32'(wr_en), 32'h1);
    check("t2_bubble_ready", 32'(rx_ready), 32'h0);
    step();
    send_byte(8'h55, 0, w);
    check("t2_after_bubble", 32'(w), 32'd1);
    q = '{8'h66, 8'h77, 8'h88};
    send_bytes(q, 1);
    wait_idle();
    check("t2_data0", obs_data[0], 32'h44332211);
    check("t2_data1", obs_data[1], 32'h88776655);
    check("t2_addr1", 32'(obs_addr[1]), 32'h04);

    // 3: zero words, rx_valid ignored while idle
    clear_stats();
    rx_data = 8'hFF; rx_valid = 1'b1;
    do_start(7'd0);
    check("t3_done", 32'(done), 32'h1);
    wait_idle();
    rx_valid = 1'b0;
    check("t3_writes", 32'(wr_count), 32'd0);
    check("t3_ready", 32'(rdy_count), 32'd0);
    check("t3_done_count", 32'(done_count), 32'd1);

    // 4: oversize request clamps to DEPTH and flags err
    clear_stats();
    do_start(7'd70);
    check("t4_err", 32'(err), 32'h1);
    for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(i), 0, w);
    wait_idle();
    check("t4_count", 32'(wr_count), 32'(DEPTH));
    check("t4_last_addr", 32'(obs_addr[DEPTH-1]), 32'hFC);
    check("t4_last_data", obs_data[DEPTH-1], 32'hFFFEFDFC);
    check("t4_err_sticky", 32'(err), 32'h1);
    do_start(7'd1);
    check("t4_err_cleared", 32'(err), 32'h0);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(q, 0);
    wait_idle();

    // 5: reset after two bytes drops the partial word
    clear_stats();
    do_start(7'd70);
    q = '{8'hA1, 8'hA2};
    send_bytes(q, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_hold", 32'(cpu_hold), 32'h0);
    check("t5_err", 32'(err), 32'h0);
    check("t5_wr_data", wr_data, 32'h0);
    check("t5_no_write", 32'(wr_count), 32'd0);
    do_start(7'd1);
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_bytes(q, 0);
    wait_idle();
    check("t5_count", 32'(wr_count), 32'd1);
    check("t5_addr", 32'(obs_addr[0]), 32'h00);
    check("t5_data", obs_data[0], 32'hDDCCBBAA);

    // 6: start mid-session is ignored
    clear_stats();
    do_start(7'd2);
    send_byte(8'h10, 0, w);
    do_start(7'd100);
    q = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    send_bytes(q, 0);
    wait_idle();
    check("t6_count", 32'(wr_count), 32'd2);
    check("t6_addr1", 32'(obs_addr[1]), 32'h04);
    check("t6_data0", obs_data[0], 32'h40302010);
    check("t6_err", 32'(err), 32'h0);
    check("t6_done", 32'(done_count), 32'd1);

    repeat (2) step();
    check("model_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
